// File: rtl/uart_tx_cfg.sv
// AXI-Stream UART transmitter with a per-frame runtime format (data bits, parity, stop bits, divider).
// The payload and every cfg_* input are captured on the handshake, so a frame never sees config changes.
module uart_tx_cfg #(
  parameter int DATA_WIDTH_MAX = 9,
  parameter int DIVIDER_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_MAX-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DIVIDER_WIDTH-1:0]  cfg_clk_divider_i,
  input  logic [3:0]                cfg_data_bits_i,
  input  logic [2:0]                cfg_parity_mode_i,
  input  logic                      cfg_stop_bits_i,
  output logic                      uart_tx_o,
  output logic                      busy_o,
  output logic                      tx_done_o
);

  // state  | meaning
  // IDLE   | line high, ready for a payload
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | parity bit (skipped when parity is none)
  // STOP   | one or two stop bits (high)
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state;
  logic [DIVIDER_WIDTH-1:0]  cnt, div_q, div_eff;
  logic [3:0]                n_q, n_eff, idx;
  logic [DATA_WIDTH_MAX-1:0] sr, data_masked;
  logic                      par_en, par_bit, par_en_q, par_q, two_stop_q, stop_idx;
  logic                      bit_end;

  always_comb begin
    div_eff = (cfg_clk_divider_i == '0) ? DIVIDER_WIDTH'(1) : cfg_clk_divider_i;
    if (cfg_data_bits_i < 4'd5)
      n_eff = 4'd5;
    else if (cfg_data_bits_i > 4'(DATA_WIDTH_MAX))
      n_eff = 4'(DATA_WIDTH_MAX);
    else
      n_eff = cfg_data_bits_i;
    for (int i = 0; i < DATA_WIDTH_MAX; i++)
      data_masked[i] = s_axis_tdata[i] & (i < int'(n_eff));
    par_en = (cfg_parity_mode_i >= 3'd1) && (cfg_parity_mode_i <= 3'd4);
    case (cfg_parity_mode_i)
      3'd1:    par_bit = ~^data_masked;
      3'd2:    par_bit = ^data_masked;
      3'd3:    par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  assign bit_end = (cnt == div_q - DIVIDER_WIDTH'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      div_q         <= '0;
      n_q           <= '0;
      idx           <= '0;
      sr            <= '0;
      par_en_q      <= 1'b0;
      par_q         <= 1'b0;
      two_stop_q    <= 1'b0;
      stop_idx      <= 1'b0;
      uart_tx_o     <= 1'b1;
      s_axis_tready <= 1'b0;
      busy_o        <= 1'b0;
      tx_done_o     <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx_o     <= 1'b1;
          busy_o        <= 1'b0;
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            div_q         <= div_eff;
            n_q           <= n_eff;
            sr            <= data_masked;
            par_en_q      <= par_en;
            par_q         <= par_bit;
            two_stop_q    <= cfg_stop_bits_i;
            cnt           <= '0;
            state         <= START;
            uart_tx_o     <= 1'b0;
            busy_o        <= 1'b1;
            s_axis_tready <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt       <= '0;
            idx       <= '0;
            uart_tx_o <= sr[0];
            sr        <= sr >> 1;
            state     <= DATA;
          end else cnt <= cnt + DIVIDER_WIDTH'(1);
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == n_q - 4'd1) begin
              stop_idx <= 1'b0;
              if (par_en_q) begin
                uart_tx_o <= par_q;
                state     <= PARITY;
              end else begin
                uart_tx_o <= 1'b1;
                state     <= STOP;
              end
            end else begin
              idx       <= idx + 4'd1;
              uart_tx_o <= sr[0];
              sr        <= sr >> 1;
            end
          end else cnt <= cnt + DIVIDER_WIDTH'(1);
        end
        PARITY: begin
          if (bit_end) begin
            cnt       <= '0;
            uart_tx_o <= 1'b1;
            state     <= STOP;
          end else cnt <= cnt + DIVIDER_WIDTH'(1);
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            // second stop bit reuses the bit counter rather than a 2D-wide compare
            if (two_stop_q && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state         <= IDLE;
              tx_done_o     <= 1'b1;
              busy_o        <= 1'b0;
              s_axis_tready <= 1'b1;
            end
          end else cnt <= cnt + DIVIDER_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
